// File: rtl/nibble_add_seq.sv
// nibble_add_seq: wide adder sequencer built around an external 4-bit adder slice.
// Operands are streamed LSB nibble first, one nibble per clock, with the carry
// chained through a register. SUM/COUT are written once, on entry to FIN.
module nibble_add_seq #(
  parameter int N_NIB = 4
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               START,
  input  logic               CIN,
  input  logic [4*N_NIB-1:0] OPA,
  input  logic [4*N_NIB-1:0] OPB,
  output logic               BUSY,
  output logic               DONE,
  output logic [4*N_NIB-1:0] SUM,
  output logic               COUT,
  output logic [3:0]         ADD_A,
  output logic [3:0]         ADD_B,
  output logic               ADD_C,
  input  logic [3:0]         ADD_F,
  input  logic               ADD_COUT
);

  localparam int W = 4 * N_NIB;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t         state_r;
  state_t         next_state_s;
  logic [W-1:0]   a_r;
  logic [W-1:0]   b_r;
  logic [W-1:0]   acc_r;
  logic [W-1:0]   acc_next_s;
  logic [W-1:0]   sum_r;
  logic           cout_r;
  logic           carry_r;
  logic [2:0]     idx_r;
  logic           last_s;

  // The slice result of the current nibble enters at the top of the accumulator;
  // after N_NIB shifts the first nibble has reached bits [3:0].
  assign acc_next_s = {ADD_F, acc_r[W-1:4]};
  assign last_s     = (idx_r == 3'(N_NIB - 1));

  assign SUM  = sum_r;
  assign COUT = cout_r;

  // State register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic: START only matters in IDLE; FIN always falls back to IDLE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (START) begin
          next_state_s = ST_RUN;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          next_state_s = ST_FIN;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_FIN:  next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Operand capture, nibble shifting, carry chaining and result write-back.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      a_r     <= {W{1'b0}};
      b_r     <= {W{1'b0}};
      acc_r   <= {W{1'b0}};
      sum_r   <= {W{1'b0}};
      cout_r  <= 1'b0;
      carry_r <= 1'b0;
      idx_r   <= 3'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (START) begin
            a_r     <= OPA;
            b_r     <= OPB;
            carry_r <= CIN;
            acc_r   <= {W{1'b0}};
            idx_r   <= 3'd0;
          end
        end
        ST_RUN: begin
          acc_r   <= acc_next_s;
          carry_r <= ADD_COUT;
          a_r     <= {4'b0000, a_r[W-1:4]};
          b_r     <= {4'b0000, b_r[W-1:4]};
          idx_r   <= idx_r + 3'd1;
          if (last_s) begin
            sum_r  <= acc_next_s;
            cout_r <= ADD_COUT;
          end
        end
        default: begin
          idx_r <= idx_r;
        end
      endcase
    end
  end

  // Output decode from the state register; the slice sees zeros outside RUN.
  always_comb begin
    BUSY  = 1'b0;
    DONE  = 1'b0;
    ADD_A = 4'd0;
    ADD_B = 4'd0;
    ADD_C = 1'b0;
    case (state_r)
      ST_RUN: begin
        BUSY  = 1'b1;
        ADD_A = a_r[3:0];
        ADD_B = b_r[3:0];
        ADD_C = carry_r;
      end
      ST_FIN: begin
        DONE = 1'b1;
      end
      ST_IDLE: begin
        BUSY = 1'b0;
      end
      default: begin
        BUSY = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_nibble_add_seq.sv
// Self-checking bench for nibble_add_seq (N_NIB=4) with a behavioural 4-bit adder slice.
module tb_nibble_add_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        cin;
  logic [15:0] opa;
  logic [15:0] opb;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic [3:0]  add_a;
  logic [3:0]  add_b;
  logic        add_c;
  logic [3:0]  add_f;
  logic        add_cout;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    logic [15:0] sum;
    logic        cout;
    bit          poke;
  } vec_t;

  exp_t        sb[$];
  logic [15:0] prev_sum;

  // External combinational 4-bit adder slice.
  assign {add_cout, add_f} = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_c};

  nibble_add_seq #(.N_NIB(4)) dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .CIN(cin), .OPA(opa), .OPB(opb),
    .BUSY(busy), .DONE(done), .SUM(sum), .COUT(cout),
    .ADD_A(add_a), .ADD_B(add_b), .ADD_C(add_c), .ADD_F(add_f), .ADD_COUT(add_cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_push(input logic [15:0] s, input logic c);
    exp_t e;
    e.sum  = s;
    e.cout = c;
    sb.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    if (sb.size() == 0) begin
      chk("unexpected_done", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("sum", {16'd0, sum}, {16'd0, e.sum});
      chk("cout", {31'd0, cout}, {31'd0, e.cout});
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after FIN.
  task automatic run_vec(input vec_t v);
    logic [3:0] ea[4];
    logic [3:0] eb[4];
    logic       ec[4];
    logic [3:0] ga[4];
    logic [3:0] gb[4];
    logic       gc[4];
    logic [4:0] t;
    logic       cc;
    int         k;
    int         busy_n;
    int         done_k;
    cc = v.c;
    for (int i = 0; i < 4; i++) begin
      ea[i] = v.a[4*i +: 4];
      eb[i] = v.b[4*i +: 4];
      ec[i] = cc;
      t     = {1'b0, ea[i]} + {1'b0, eb[i]} + {4'b0000, cc};
      cc    = t[4];
      ga[i] = 4'd0;
      gb[i] = 4'd0;
      gc[i] = 1'b0;
    end
    opa = v.a;
    opb = v.b;
    cin = v.c;
    start = 1'b1;
    expect_push(v.sum, v.cout);
    @(negedge clk);
    start  = 1'b0;
    k      = 1;
    busy_n = 0;
    done_k = 0;
    chk("sum_hold_in_run", {16'd0, sum}, {16'd0, prev_sum});
    while (k <= 20 && done_k == 0) begin
      if (busy) begin
        if (busy_n < 4) begin
          ga[busy_n] = add_a;
          gb[busy_n] = add_b;
          gc[busy_n] = add_c;
        end
        busy_n++;
      end
      if (done) begin
        done_k = k;
        sb_check();
        chk("fin_add_a", {28'd0, add_a}, 32'd0);
      end
      if (v.poke && k == 2) begin
        start = 1'b1;
        opa   = 16'h1357;
        opb   = 16'h2468;
        cin   = ~v.c;
      end
      if (v.poke && k == 3) begin
        start = 1'b0;
      end
      if (done_k == 0) begin
        @(negedge clk);
        k++;
      end
    end
    if (done_k == 0) begin
      chk("done_timeout", 32'd0, 32'd1);
    end else begin
      chk("done_latency", done_k - 1, 32'd4);
    end
    chk("busy_cycles", busy_n, 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("add_a_seq", {28'd0, ga[i]}, {28'd0, ea[i]});
      chk("add_b_seq", {28'd0, gb[i]}, {28'd0, eb[i]});
      chk("add_c_seq", {31'd0, gc[i]}, {31'd0, ec[i]});
    end
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("no_extra_done", {31'd0, done}, 32'd0);
    prev_sum = v.sum;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    vec_t v;
    int   ndone;
    int   last_k;

    vecs[0] = '{a: 16'h0000, b: 16'h0000, c: 1'b0, sum: 16'h0000, cout: 1'b0, poke: 1'b0};
    vecs[1] = '{a: 16'h1234, b: 16'h4321, c: 1'b0, sum: 16'h5555, cout: 1'b0, poke: 1'b0};
    vecs[2] = '{a: 16'hFFFF, b: 16'h0001, c: 1'b0, sum: 16'h0000, cout: 1'b1, poke: 1'b0};
    vecs[3] = '{a: 16'hFFFF, b: 16'hFFFF, c: 1'b1, sum: 16'hFFFF, cout: 1'b1, poke: 1'b0};
    vecs[4] = '{a: 16'h8000, b: 16'h7FFF, c: 1'b1, sum: 16'h0000, cout: 1'b1, poke: 1'b1};
    vecs[5] = '{a: 16'h00FF, b: 16'h0001, c: 1'b0, sum: 16'h0100, cout: 1'b0, poke: 1'b0};
    vecs[6] = '{a: 16'hABCD, b: 16'h1111, c: 1'b1, sum: 16'hBCDF, cout: 1'b0, poke: 1'b0};

    clk      = 1'b0;
    rst_n    = 1'b0;
    start    = 1'b0;
    cin      = 1'b0;
    opa      = 16'h0000;
    opb      = 16'h0000;
    prev_sum = 16'h0000;

    // Reset state
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sum", {16'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_add_a", {28'd0, add_a}, 32'd0);
    chk("rst_add_b", {28'd0, add_b}, 32'd0);
    chk("rst_add_c", {31'd0, add_c}, 32'd0);

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i]);
    end

    // Reset asserted during the second RUN cycle aborts the addition.
    opa   = 16'hAAAA;
    opb   = 16'h5555;
    cin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_sum", {16'd0, sum}, 32'd0);
    chk("abort_cout", {31'd0, cout}, 32'd0);
    chk("abort_add_a", {28'd0, add_a}, 32'd0);
    chk("abort_add_c", {31'd0, add_c}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("abort_no_done", ndone, 32'd0);
    prev_sum = 16'h0000;

    v = '{a: 16'h0F0F, b: 16'h0101, c: 1'b0, sum: 16'h1010, cout: 1'b0, poke: 1'b0};
    run_vec(v);

    // START held high: one result every N_NIB+2 cycles.
    opa   = 16'h0003;
    opb   = 16'h0006;
    cin   = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_push(16'h0009, 1'b0);
    end
    ndone  = 0;
    last_k = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        sb_check();
        if (ndone == 1) begin
          chk("held_first_done", k, 32'd5);
        end else begin
          chk("held_spacing", k - last_k, 32'd6);
        end
        last_k = k;
        if (ndone == 3) begin
          start = 1'b0;
          break;
        end
      end
    end
    chk("held_done_count", ndone, 32'd3);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("held_no_more_done", ndone, 32'd0);
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nibble_add_seq.md
# nibble_add_seq

Sequencer that performs wide binary addition by driving the team's existing 4-bit adder slice (inputs A, B, C; outputs F, COUT) one nibble per clock. It serialises operands of 4×N_NIB bits LSB-nibble first and chains the carry through a register. It presents a start/busy/done handshake to the surrounding design. The adder slice stays external and purely combinational; this block owns only control, operand and result registers, and carry state.

## Interface
- N_NIB, default 4: number of nibbles per operand; operand width W = 4×N_NIB; legal range 2..8.
- CLK  in  1  sole clock; all logic on rising edge.
- RST_N  in  1  reset, synchronous and active-low.
- START  in  1  request; sampled only in IDLE.
- CIN  in  1  carry-in of the wide addition; captured with START.
- OPA  in  W  operand A; captured with START.
- OPB  in  W  operand B; captured with START.
- BUSY  out  1  high while in RUN.
- DONE  out  1  one-cycle pulse; SUM/COUT valid from this cycle.
- SUM  out  W  registered result; holds until the next result is written.
- COUT  out  1  registered carry-out of the wide addition.
- ADD_A  out  4  to adder slice A.
- ADD_B  out  4  to adder slice B.
- ADD_C  out  1  to adder slice C.
- ADD_F  in  4  from adder slice F; same-cycle combinational response.
- ADD_COUT  in  1  from adder slice COUT.

## Operation
- States: IDLE, RUN, FIN. Reset value: IDLE.
- IDLE: BUSY=0, DONE=0, ADD_A/ADD_B/ADD_C=0.
  - START=1 at an edge loads OPA/OPB into operand shift registers, CIN into carry register, clears nibble index and accumulator, then goes to RUN.
- RUN: ADD_A/ADD_B = low nibble of the A/B shift registers; ADD_C = carry register; BUSY=1. Each edge:
  - accumulator shifts right 4 with ADD_F inserted at bits [W-1:W-4];
  - carry register <= ADD_COUT;
  - operand registers shift right 4;
  - index increments.
- On the edge where index = N_NIB-1: SUM <= final accumulator (including this nibble), COUT <= ADD_COUT, then go to FIN.
- FIN: DONE=1, BUSY=0, adder drives 0; unconditionally returns to IDLE next edge.
- START is ignored in RUN and FIN; no queuing. OPA/OPB/CIN changes after capture have no effect.
- Arithmetic: SUM = (OPA + OPB + CIN) mod 2^W; COUT = bit W of the full sum. Wrap-around is not an error.
- SUM/COUT change only on entry to FIN (or reset); they are stable during RUN and still show the previous result.
- Reset overrides everything, including mid-RUN:
  - next edge: IDLE; SUM=0, COUT=0, BUSY=0, DONE=0, ADD_*=0;
  - the aborted operation produces no DONE.

## Timing
- Accept edge e0 (START=1 in IDLE). RUN occupies the cycles after edges e0..e(N_NIB-1); nibble i is on ADD_* in the cycle after edge e(i).
- DONE is high for exactly the cycle after edge e(N_NIB). Latency START-accept to DONE = N_NIB cycles.
- Earliest next accept: edge e(N_NIB+2). With START held high, throughput is one addition per N_NIB+2 cycles.
- ADD_F/ADD_COUT must settle within one cycle of ADD_* changing. There is no combinational path from inputs to BUSY/DONE/SUM/COUT.

## Test plan
Bench instantiates the 4-bit adder slice, N_NIB=4.
- Reset, 0x0000+0x0000, CIN=0 -> DONE 4 cycles after accept, SUM=0x0000, COUT=0, BUSY high exactly 4 cycles.
- 0x1234+0x4321, CIN=0 -> ADD_A sequence 4,3,2,1; ADD_B 1,2,3,4; SUM=0x5555, COUT=0.
- 0xFFFF+0x0001, CIN=0 -> ADD_C sequence 0,1,1,1; SUM=0x0000, COUT=1. Then 0xFFFF+0xFFFF, CIN=1 -> SUM=0xFFFF, COUT=1.
- 0x8000+0x7FFF, CIN=1 -> SUM=0x0000, COUT=1. START and new operands pulsed during RUN -> ignored, result unchanged, no extra DONE.
- RST_N low for one edge at second RUN cycle of 0xAAAA+0x5555 -> next cycle IDLE, SUM=0, COUT=0, no DONE. Subsequent 0x0F0F+0x0101, CIN=0 -> SUM=0x1010, COUT=0.
- START held high with fixed operands 0x0003+0x0006, CIN=0 -> DONE pulses every 6 cycles, SUM=0x0009 each time.
